sram_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory bus between the CPU's instruction SRAM port and data SRAM port.
- Generates the i_stall and d_stall inputs that the CPU wrapper consumes.
- Holds each completed read result until the whole pipeline advances.
- Sits between the SRAM-interface CPU wrapper and the unified memory/bus bridge.

---
 rtl/sram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one variable-latency memory bus between the CPU instruction and data SRAM ports.
// Each completed read is held until the whole pipeline advances; stalls are combinational.
module sram_port_arbiter #(
    parameter int unsigned DATA_FIRST = 1,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        i_stall,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err
);

    typedef enum logic {StIdle, StBusy} state_e;

    // Last BUSY cycle index before a missing ack forces an abort.
    localparam logic [15:0] WaitLast = 16'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic        grant_data_q;
    logic        mem_req_q, mem_wr_q, mem_err_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [15:0] wait_cnt_q;
    logic        i_done_q, d_done_q;
    logic [31:0] hold_i_q, hold_d_q;

    logic        pend_i, pend_d, advance, pick_data, issue, timeout, finish;
    logic [31:0] fin_data;

    assign pend_i    = inst_sram_en & ~i_done_q;
    assign pend_d    = data_sram_en & ~d_done_q;
    assign advance   = ~pend_i & ~pend_d;
    assign pick_data = pend_d & (~pend_i | (DATA_FIRST != 0));
    assign issue     = (state_q == StIdle) & (pend_i | pend_d);
    assign timeout   = (state_q == StBusy) & ~mem_ack & (wait_cnt_q == WaitLast);
    assign finish    = (state_q == StBusy) & (mem_ack | timeout);
    // An aborted access returns zero data.
    assign fin_data  = mem_ack ? mem_rdata : 32'h0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE when anything is pending, return when the access ends.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (pend_i | pend_d) state_d = StBusy;
            StBusy: if (finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: stalls are combinational, everything else comes from registers.
    always_comb begin
        i_stall         = pend_i;
        d_stall         = pend_d;
        mem_req         = mem_req_q;
        mem_wr          = mem_wr_q;
        mem_wstrb       = mem_wstrb_q;
        mem_addr        = mem_addr_q;
        mem_wdata       = mem_wdata_q;
        mem_err         = mem_err_q;
        inst_sram_rdata = hold_i_q;
        data_sram_rdata = hold_d_q;
    end

    // Bus request registers and the BUSY wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wstrb_q  <= 4'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            grant_data_q <= 1'b0;
            wait_cnt_q   <= 16'h0;
        end else if (issue) begin
            mem_req_q    <= 1'b1;
            grant_data_q <= pick_data;
            wait_cnt_q   <= 16'h0;
            if (pick_data) begin
                mem_wr_q    <= |data_sram_wen;
                mem_wstrb_q <= data_sram_wen;
                mem_addr_q  <= data_sram_addr;
                mem_wdata_q <= data_sram_wdata;
            end else begin
                mem_wr_q    <= 1'b0;
                mem_wstrb_q <= 4'h0;
                mem_addr_q  <= inst_sram_addr;
                mem_wdata_q <= 32'h0;
            end
        end else if (finish) begin
            mem_req_q <= 1'b0;
        end else if (state_q == StBusy) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    // Done flags, held read data and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            hold_i_q  <= 32'h0;
            hold_d_q  <= 32'h0;
            mem_err_q <= 1'b0;
        end else begin
            if (advance) begin
                i_done_q <= 1'b0;
                d_done_q <= 1'b0;
            end
            // A completion overrides a same-cycle advance (flushed port still records done).
            if (finish) begin
                if (grant_data_q) begin
                    d_done_q <= 1'b1;
                    if (!mem_wr_q) hold_d_q <= fin_data;
                end else begin
                    i_done_q <= 1'b1;
                    hold_i_q <= fin_data;
                end
            end
            if (timeout) mem_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a transaction-level reference model.
module tb_sram_port_arbiter;

    localparam int unsigned MaxWait   = 4;
    localparam bit          DataFirst = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        i_stall;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .DATA_FIRST(1),
        .MAX_WAIT  (MaxWait)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .i_stall        (i_stall),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .d_stall        (d_stall),
        .mem_req        (mem_req),
        .mem_wr         (mem_wr),
        .mem_wstrb      (mem_wstrb),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .mem_err        (mem_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-port completion, held data, and the one access in flight.
    bit          m_i_done, m_d_done, m_err, m_busy, m_gnt_data, m_wr;
    logic [31:0] m_hold_i, m_hold_d, m_addr, m_wdata;
    logic [3:0]  m_strb;
    int          m_age;

    // Memory responder and observation state.
    int          lat;
    int          req_age;
    bit          spur;
    bit          prev_req;
    bit          last_i_stall, last_d_stall;
    int          pulses;
    int          req_cycles;
    logic [31:0] req_addr[$];
    bit          cap_wr;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wdata;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic model_reset();
        m_i_done = 0; m_d_done = 0; m_err = 0; m_busy = 0; m_gnt_data = 0; m_wr = 0;
        m_hold_i = '0; m_hold_d = '0; m_addr = '0; m_wdata = '0; m_strb = '0; m_age = 0;
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic check_outputs();
        check1("i_stall", i_stall, inst_sram_en && !m_i_done);
        check1("d_stall", d_stall, data_sram_en && !m_d_done);
        check1("mem_req", mem_req, m_busy);
        check1("mem_wr", mem_wr, m_wr);
        check("mem_wstrb", 32'(mem_wstrb), 32'(m_strb));
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check1("mem_err", mem_err, m_err);
        check("inst_rdata", inst_sram_rdata, m_hold_i);
        check("data_rdata", data_sram_rdata, m_hold_d);
    endtask

    // Advance the model across one clock edge using this cycle's inputs.
    task automatic model_step();
        bit pi, pd;
        logic [31:0] rd;
        pi = inst_sram_en && !m_i_done;
        pd = data_sram_en && !m_d_done;
        if (!pi && !pd) begin
            m_i_done = 0;
            m_d_done = 0;
        end
        if (m_busy) begin
            if (mem_ack || m_age == int'(MaxWait) - 1) begin
                rd = mem_ack ? mem_rdata : 32'h0;
                if (!mem_ack) m_err = 1;
                if (m_gnt_data) begin
                    m_d_done = 1;
                    if (!m_wr) m_hold_d = rd;
                end else begin
                    m_i_done = 1;
                    m_hold_i = rd;
                end
                m_busy = 0;
            end else begin
                m_age++;
            end
        end else if (pi || pd) begin
            m_gnt_data = pd && (DataFirst || !pi);
            if (m_gnt_data) begin
                m_addr = data_sram_addr; m_wr = (data_sram_wen != 0);
                m_strb = data_sram_wen;  m_wdata = data_sram_wdata;
            end else begin
                m_addr = inst_sram_addr; m_wr = 0; m_strb = '0; m_wdata = '0;
            end
            m_busy = 1;
            m_age  = 0;
        end
    endtask

    // One clock cycle: memory response, comparison, model update, then the edge.
    task automatic tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_0000;
        if (spur) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hFFFF_0000;
        end else if (mem_req && lat >= 0 && req_age == lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_data(mem_addr);
        end
        #1;
        check_outputs();
        last_i_stall = i_stall;
        last_d_stall = d_stall;
        if (mem_req && !prev_req) begin
            pulses++;
            req_addr.push_back(mem_addr);
            cap_wr = mem_wr; cap_strb = mem_wstrb; cap_wdata = mem_wdata;
        end
        prev_req = mem_req;
        if (mem_req) req_cycles++;
        model_step();
        if (mem_req && !mem_ack) req_age++;
        else req_age = 0;
        @(posedge clk);
        #1;
    endtask

    // Run until both stalls are low (that advance cycle included); count stall-high cycles.
    task automatic run_until_free(output int i_hi, output int d_hi);
        i_hi = 0;
        d_hi = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (last_i_stall) i_hi++;
            if (last_d_stall) d_hi++;
            if (!last_i_stall && !last_d_stall) return;
        end
        check1("advance_within_bound", 1'b0, 1'b1);
    endtask

    task automatic clear_obs();
        pulses = 0;
        req_cycles = 0;
        req_addr.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ih, dh;
        rst = 1'b0;
        inst_sram_en = 0; inst_sram_addr = '0;
        data_sram_en = 0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        lat = 1; req_age = 0; spur = 0; prev_req = 0;
        clear_obs();
        model_reset();
        #12;
        check1("reset_mem_req", mem_req, 1'b0);
        check1("reset_mem_err", mem_err, 1'b0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_inst_rdata", inst_sram_rdata, 32'h0);
        check("reset_data_rdata", data_sram_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Instruction fetch only, ack one cycle after the request.
        inst_sram_en = 1; inst_sram_addr = 32'hBFC0_0000; lat = 1;
        run_until_free(ih, dh);
        check("t1_i_stall_cycles", 32'(ih), 32'd3);
        check("t1_d_stall_cycles", 32'(dh), 32'd0);
        check("t1_inst_rdata", inst_sram_rdata, 32'h2408_0001);
        inst_sram_en = 0;
        tick();

        // Both ports read at once: data goes first, inst follows after one IDLE cycle.
        clear_obs();
        inst_sram_en = 1; inst_sram_addr = 32'h100;
        data_sram_en = 1; data_sram_addr = 32'h200; data_sram_wen = 4'h0;
        run_until_free(ih, dh);
        check("t2_d_stall_cycles", 32'(dh), 32'd3);
        check("t2_i_stall_cycles", 32'(ih), 32'd6);
        check("t2_pulses", 32'(pulses), 32'd2);
        if (req_addr.size() == 2) begin
            check("t2_first_addr", req_addr[0], 32'h200);
            check("t2_second_addr", req_addr[1], 32'h100);
        end else begin
            check("t2_addr_count", 32'(req_addr.size()), 32'd2);
        end
        check("t2_data_rdata", data_sram_rdata, 32'h0200_FDFF);
        check("t2_inst_rdata", inst_sram_rdata, 32'h0100_FEFF);
        inst_sram_en = 0; data_sram_en = 0;
        tick();

        // Data write: bus fields come from the data port, held read data is untouched.
        clear_obs();
        data_sram_en = 1; data_sram_wen = 4'b0011;
        data_sram_addr = 32'h80; data_sram_wdata = 32'hDEAD_BEEF;
        run_until_free(ih, dh);
        check("t3_d_stall_cycles", 32'(dh), 32'd3);
        check1("t3_mem_wr", cap_wr, 1'b1);
        check("t3_mem_wstrb", 32'(cap_strb), 32'h3);
        check("t3_mem_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("t3_data_rdata_kept", data_sram_rdata, 32'h0200_FDFF);
        data_sram_en = 0; data_sram_wen = '0;
        tick();

        // Zero-latency ack: back-to-back fetches complete every three cycles.
        clear_obs();
        lat = 0;
        inst_sram_en = 1;
        for (int k = 0; k < 3; k++) begin
            inst_sram_addr = 32'h1000 + 32'(k * 4);
            run_until_free(ih, dh);
            check("t4_i_stall_cycles", 32'(ih), 32'd2);
        end
        check("t4_pulses", 32'(pulses), 32'd3);
        check("t4_inst_rdata", inst_sram_rdata, 32'h1008_EFF7);
        inst_sram_en = 0;

        // Stray ack while idle must be ignored.
        spur = 1;
        tick();
        spur = 0;
        tick();
        check("stray_ack_inst_rdata", inst_sram_rdata, 32'h1008_EFF7);
        check1("stray_ack_mem_req", mem_req, 1'b0);

        // Timeout: no ack, abort after MaxWait BUSY cycles, then a normal access.
        clear_obs();
        lat = -1;
        inst_sram_en = 1; inst_sram_addr = 32'h2000;
        run_until_free(ih, dh);
        check("t5_i_stall_cycles", 32'(ih), 32'd5);
        check("t5_busy_cycles", 32'(req_cycles), 32'd4);
        check1("t5_mem_err", mem_err, 1'b1);
        check("t5_inst_rdata", inst_sram_rdata, 32'h0);
        lat = 1;
        inst_sram_addr = 32'h3000;
        run_until_free(ih, dh);
        check("t5_next_i_stall_cycles", 32'(ih), 32'd3);
        check("t5_next_inst_rdata", inst_sram_rdata, 32'h3000_CFFF);
        check1("t5_mem_err_sticky", mem_err, 1'b1);

        // Asynchronous reset while the instruction access is on the bus.
        clear_obs();
        lat = 2;
        inst_sram_addr = 32'h5000;
        data_sram_en = 1; data_sram_addr = 32'h6000; data_sram_wen = 4'h0;
        for (int k = 0; k < 5; k++) tick();
        check1("t6_pre_mem_req", mem_req, 1'b1);
        check1("t6_pre_d_stall", d_stall, 1'b0);
        rst = 1'b0;
        #2;
        check1("t6_rst_mem_req", mem_req, 1'b0);
        check1("t6_rst_mem_err", mem_err, 1'b0);
        check("t6_rst_inst_rdata", inst_sram_rdata, 32'h0);
        check("t6_rst_data_rdata", data_sram_rdata, 32'h0);
        check1("t6_rst_i_stall", i_stall, 1'b1);
        check1("t6_rst_d_stall", d_stall, 1'b1);
        model_reset();
        mem_ack = 0; req_age = 0; prev_req = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        clear_obs();
        lat = 1;
        run_until_free(ih, dh);
        check("t6_d_stall_cycles", 32'(dh), 32'd3);
        check("t6_i_stall_cycles", 32'(ih), 32'd6);
        if (req_addr.size() > 0) check("t6_first_addr", req_addr[0], 32'h6000);
        else check("t6_addr_count", 32'(req_addr.size()), 32'd2);
        check("t6_data_rdata", data_sram_rdata, 32'h6000_9FFF);
        check("t6_inst_rdata", inst_sram_rdata, 32'h5000_AFFF);
        inst_sram_en = 0; data_sram_en = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
